// File: rtl/hdr_weight_pipe.sv
// Per-exposure hat weights and weight sum for K co-located HDR pixels, 2-stage valid/ready pipeline.
// Optional frame clip statistics when HDR_WEIGHT_STATS_EN is defined.
module hdr_weight_pipe #(
    parameter  int N  = 6,
    parameter  int K  = 3,
    localparam int SW = N + $clog2(K)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic           in_sof,
    input  logic           in_mode,
    input  logic [K*N-1:0] in_pix,
    output logic           out_valid,
    input  logic           out_ready,
    output logic           out_sof,
    output logic [K*N-1:0] out_w,
    output logic [SW-1:0]  out_wsum,
    output logic           out_all_clipped
`ifdef HDR_WEIGHT_STATS_EN
    ,
    output logic [31:0]    stat_clip_cnt,
    output logic           stat_valid
`endif
);

    localparam logic [K*N-1:0] FALLBACK_W = {K{N'(1)}};

    logic           s1_adv;
    logic           s1_valid_q;
    logic           s1_sof_q;
    logic [K*N-1:0] s1_w_q;
    logic           s1_allzero_q;
    logic [K*N-1:0] s1_w_d;
    logic           s1_allzero_d;
    logic [N-1:0]   pix_c;
    logic [N-1:0]   hat_c;
    logic           clip_c;

    logic           out_valid_q;
    logic           out_sof_q;
    logic [K*N-1:0] out_w_q;
    logic [SW-1:0]  out_wsum_q;
    logic           out_all_clipped_q;
    logic [K*N-1:0] out_w_d;
    logic [SW-1:0]  out_wsum_d;

    // S2 can take a new beat when it is empty or its beat is leaving now.
    assign s1_adv   = ~out_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s1_adv;

    // The all-zero flag already folds in the mode: plain-hat weights are never 0.
    always_comb begin
        s1_w_d       = '0;
        s1_allzero_d = 1'b1;
        pix_c        = '0;
        hat_c        = '0;
        clip_c       = 1'b0;
        for (int i = 0; i < K; i++) begin
            pix_c  = in_pix[i*N +: N];
            clip_c = (pix_c == '0) || (pix_c == '1);
            hat_c  = pix_c[N-1] ? (~pix_c + N'(1)) : (pix_c + N'(1));
            if (in_mode && clip_c) begin
                hat_c = '0;
            end
            s1_w_d[i*N +: N] = hat_c;
            if (hat_c != '0) begin
                s1_allzero_d = 1'b0;
            end
        end
    end

    always_comb begin
        out_wsum_d = '0;
        out_w_d    = s1_w_q;
        if (s1_allzero_q) begin
            out_w_d    = FALLBACK_W;
            out_wsum_d = SW'(K);
        end else begin
            for (int i = 0; i < K; i++) begin
                out_wsum_d = out_wsum_d + {{(SW-N){1'b0}}, s1_w_q[i*N +: N]};
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q        <= 1'b0;
            s1_sof_q          <= 1'b0;
            s1_w_q            <= '0;
            s1_allzero_q      <= 1'b0;
            out_valid_q       <= 1'b0;
            out_sof_q         <= 1'b0;
            out_w_q           <= '0;
            out_wsum_q        <= '0;
            out_all_clipped_q <= 1'b0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) begin
                    s1_sof_q     <= in_sof;
                    s1_w_q       <= s1_w_d;
                    s1_allzero_q <= s1_allzero_d;
                end
            end
            if (s1_adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    out_sof_q         <= s1_sof_q;
                    out_w_q           <= out_w_d;
                    out_wsum_q        <= out_wsum_d;
                    out_all_clipped_q <= s1_allzero_q;
                end
            end
        end
    end

    assign out_valid       = out_valid_q;
    assign out_sof         = out_sof_q;
    assign out_w           = out_w_q;
    assign out_wsum        = out_wsum_q;
    assign out_all_clipped = out_all_clipped_q;

`ifdef HDR_WEIGHT_STATS_EN
    localparam int CW = $clog2(K + 1);

    logic [CW-1:0] clips_d;
    logic [CW-1:0] s1_clips_q;
    logic [CW-1:0] s2_clips_q;
    logic [31:0]   frame_cnt_q;
    logic [31:0]   stat_clip_cnt_q;
    logic          stat_valid_q;
    logic [32:0]   cnt_sum;
    logic          out_fire;

    always_comb begin
        clips_d = '0;
        for (int i = 0; i < K; i++) begin
            if ((in_pix[i*N +: N] == '0) || (in_pix[i*N +: N] == '1)) begin
                clips_d = clips_d + CW'(1);
            end
        end
    end

    assign out_fire = out_valid_q & out_ready;
    assign cnt_sum  = {1'b0, frame_cnt_q} + 33'(s2_clips_q);

    // Clip counts ride alongside the beat so they are tallied only at the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_clips_q      <= '0;
            s2_clips_q      <= '0;
            frame_cnt_q     <= '0;
            stat_clip_cnt_q <= '0;
            stat_valid_q    <= 1'b0;
        end else begin
            if (in_ready && in_valid) begin
                s1_clips_q <= clips_d;
            end
            if (s1_adv && s1_valid_q) begin
                s2_clips_q <= s1_clips_q;
            end
            stat_valid_q <= out_fire & out_sof_q;
            if (out_fire) begin
                if (out_sof_q) begin
                    stat_clip_cnt_q <= frame_cnt_q;
                    frame_cnt_q     <= 32'(s2_clips_q);
                end else begin
                    frame_cnt_q <= cnt_sum[32] ? '1 : cnt_sum[31:0];
                end
            end
        end
    end

    assign stat_clip_cnt = stat_clip_cnt_q;
    assign stat_valid    = stat_valid_q;
`endif

endmodule
